// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the multi-outstanding fetch unit.
//   - default address/data widths and reset fetch address
//   - IB entry layout {pc, instr} and its field offsets
//   - cnt_w(): width of a counter that must hold 0..n inclusive
package fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  // IB entry at default widths; pc occupies the upper bits.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } ib_entry_t;

  localparam int IB_INSTR_LSB = 0;
  localparam int IB_PC_LSB    = DATA_W_DEF;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush and occupancy count.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_push/i_wdata  write one entry (ignored when full unless popping)
//   i_pop        remove head entry (ignored when empty)
//   i_flush      discard all entries this cycle
//   o_rdata      head entry (valid when o_count != 0)
//   o_count      number of stored entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push, w_do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full FIFO can still take a write if the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= nxt(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; validity is carried by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_pipe.sv
// fetch_pipe: multi-outstanding sequential instruction fetch unit.
// Issues in-order fetches, tracks up to MAX_OUT requests+buffered words,
// and pushes {pc, instr} entries into the instruction buffer (IB).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   o_mem_req/o_mem_req_addr           fetch request and address
//   i_mem_req_rdy                      memory accepts the request this cycle
//   i_mem_resp_valid/_addr/_data       in-order response from memory
//   o_ib_push/o_ib_push_data           IB push, {pc, instr} with pc on top
//   i_ib_full                          IB cannot accept
//   i_branch_taken/i_branch_target     redirect fetch
//   o_err                              sticky protocol error
module fetch_pipe
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_OUT = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     o_mem_req,
  output logic [ADDR_W-1:0]        o_mem_req_addr,
  input  logic                     i_mem_req_rdy,
  input  logic                     i_mem_resp_valid,
  input  logic [ADDR_W-1:0]        i_mem_resp_addr,
  input  logic [DATA_W-1:0]        i_mem_resp_data,
  output logic                     o_ib_push,
  output logic [ADDR_W+DATA_W-1:0] o_ib_push_data,
  input  logic                     i_ib_full,
  input  logic                     i_branch_taken,
  input  logic [ADDR_W-1:0]        i_branch_target,
  output logic                     o_err
);

  localparam int CNT_W = cnt_w(MAX_OUT);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_err;

  logic [CNT_W-1:0]  w_out_cnt, w_buf_cnt;
  logic [CNT_W:0]    w_used;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_issue, w_resp_deq, w_resp_ok, w_buf_wr, w_drop_dec;

  // Credit uses registered counts only: a slot freed this cycle is reusable next cycle.
  assign w_used    = {1'b0, w_out_cnt} + {1'b0, w_buf_cnt};
  assign o_mem_req = !reset && !i_branch_taken && (w_used < (CNT_W+1)'(MAX_OUT));
  assign o_mem_req_addr = r_pc;
  assign w_issue   = o_mem_req && i_mem_req_rdy;

  // Any response dequeues the tracker if something is outstanding; a
  // mismatching one is still consumed so later in-order responses line up.
  assign w_resp_deq = i_mem_resp_valid && (w_out_cnt != '0);
  assign w_resp_ok  = w_resp_deq && (i_mem_resp_addr == w_head_addr);
  assign w_drop_dec = w_resp_ok && !i_branch_taken && (r_drop_cnt != '0);
  assign w_buf_wr   = w_resp_ok && !i_branch_taken && (r_drop_cnt == '0);

  assign o_ib_push = !reset && !i_branch_taken && !i_ib_full && (w_buf_cnt != '0);
  assign o_err     = r_err;

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_issue),
    .i_wdata (r_pc),
    .i_pop   (w_resp_deq),
    .i_flush (1'b0),
    .o_rdata (w_head_addr),
    .o_count (w_out_cnt)
  );

  fetch_fifo #(.WIDTH(ADDR_W+DATA_W), .DEPTH(MAX_OUT)) u_respbuf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_buf_wr),
    .i_wdata ({w_head_addr, i_mem_resp_data}),
    .i_pop   (o_ib_push),
    .i_flush (i_branch_taken),
    .o_rdata (o_ib_push_data),
    .o_count (w_buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      // Unexpected (nothing outstanding) or out-of-order response.
      if (i_mem_resp_valid && !w_resp_ok) r_err <= 1'b1;
      if (i_branch_taken) begin
        r_pc       <= i_branch_target;
        // Everything still outstanding after this cycle's dequeue is stale.
        r_drop_cnt <= w_out_cnt - CNT_W'(w_resp_deq);
      end else begin
        if (w_issue)    r_pc       <= r_pc + 1'b1;
        if (w_drop_dec) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed + randomized bench for fetch_pipe.
// The reference tags every accepted request with a fetch epoch (bumped on
// each branch); a returned word is delivered only if its epoch is current.
module tb_fetch_pipe;
  import fetch_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_req_rdy = 1'b0;
  logic          i_mem_resp_valid = 1'b0;
  logic [AW-1:0] i_mem_resp_addr = '0;
  logic [DW-1:0] i_mem_resp_data = '0;
  logic          o_ib_push;
  logic [AW+DW-1:0] o_ib_push_data;
  logic          i_ib_full = 1'b0;
  logic          i_branch_taken = 1'b0;
  logic [AW-1:0] i_branch_target = '0;
  logic          o_err;

  fetch_pipe #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .o_mem_req(o_mem_req), .o_mem_req_addr(o_mem_req_addr), .i_mem_req_rdy(i_mem_req_rdy),
    .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_addr(i_mem_resp_addr),
    .i_mem_resp_data(i_mem_resp_data),
    .o_ib_push(o_ib_push), .o_ib_push_data(o_ib_push_data), .i_ib_full(i_ib_full),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model + compare (mid-cycle, negedge) -------
  typedef struct { logic [AW-1:0] addr; int ep; } infl_t;
  infl_t             outq[$];
  logic [AW+DW-1:0]  bufq[$];
  int                epoch = 0;
  logic [AW-1:0]     nxt_pc = '0;
  logic              exp_err = 1'b0;
  logic              exp_req, exp_push;
  infl_t             h;

  int                ccyc = 0;
  logic [AW-1:0]     push_pc[$];
  int                push_cyc[$];
  bit                req_log[64];
  logic [AW-1:0]     first_req;
  bit                got_first = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("req_in_reset", o_mem_req, 0);
      chk("push_in_reset", o_ib_push, 0);
      outq.delete(); bufq.delete();
      nxt_pc = 16'h0000; exp_err = 1'b0; ccyc = 0;
      push_pc.delete(); push_cyc.delete(); got_first = 0;
      foreach (req_log[i]) req_log[i] = 0;
    end else begin
      chk("err", o_err, exp_err);
      exp_req = !i_branch_taken && (outq.size() + bufq.size() < MO);
      chk("mem_req", o_mem_req, exp_req);
      if (o_mem_req) chk("req_addr", o_mem_req_addr, nxt_pc);
      exp_push = (bufq.size() > 0) && !i_ib_full && !i_branch_taken;
      chk("ib_push", o_ib_push, exp_push);
      if (o_ib_push && bufq.size() > 0) chk("push_data", o_ib_push_data, bufq[0]);
      // logs for the literal checks
      if (o_ib_push) begin
        push_pc.push_back(o_ib_push_data[IB_PC_LSB +: AW]);
        push_cyc.push_back(ccyc);
      end
      if (ccyc < 64) req_log[ccyc] = o_mem_req;
      if (o_mem_req && i_mem_req_rdy && !got_first) begin
        first_req = o_mem_req_addr; got_first = 1;
      end
      // advance the model by this cycle's events
      if (exp_push) void'(bufq.pop_front());
      if (i_mem_resp_valid) begin
        if (outq.size() == 0) exp_err = 1'b1;
        else begin
          h = outq.pop_front();
          if (i_mem_resp_addr != h.addr) exp_err = 1'b1;
          else if (!i_branch_taken && h.ep == epoch)
            bufq.push_back({h.addr, i_mem_resp_data});
        end
      end
      if (exp_req && i_mem_req_rdy) begin
        outq.push_back('{nxt_pc, epoch});
        nxt_pc = nxt_pc + 1'b1;
      end
      if (i_branch_taken) begin
        bufq.delete(); epoch++; nxt_pc = i_branch_target;
      end
      ccyc++;
    end
  end

  // ---------------- driver with in-order memory model ---------------------
  typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
  mreq_t memq[$];
  int    tcyc = 0;
  int    lat = 1;
  bit    corrupt4 = 0;

  task automatic step(input bit rst, input bit br, input logic [AW-1:0] tgt,
                      input bit full, input bit rdy);
    mreq_t m;
    @(posedge clk); #1;
    reset = rst; i_branch_taken = br; i_branch_target = tgt;
    i_ib_full = full; i_mem_req_rdy = rdy;
    i_mem_resp_valid = 1'b0; i_mem_resp_addr = '0; i_mem_resp_data = '0;
    if (rst) memq.delete();
    else if (memq.size() > 0 && memq[0].due <= tcyc) begin
      m = memq.pop_front();
      i_mem_resp_valid = 1'b1;
      i_mem_resp_addr  = m.addr;
      i_mem_resp_data  = word_of(m.addr);
      if (corrupt4 && m.addr == 16'h0004) i_mem_resp_addr = 16'h0005;
    end
    @(negedge clk);
    if (!rst && o_mem_req && i_mem_req_rdy) memq.push_back('{o_mem_req_addr, tcyc + lat});
    tcyc++;
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1, 0, '0, 0, 1);
  endtask

  // Checks that at least n pushes were logged; counts as one comparison.
  function automatic bit have(input string nm, input int n);
    n_vec++;
    if (push_pc.size() < n) begin
      n_err++;
      $display("FAIL %s: got %0d pushes, expected at least %0d", nm, push_pc.size(), n);
      return 0;
    end
    return 1;
  endfunction

  initial begin
    logic [AW-1:0] t;
    int k;

    // Streaming, then IB full during cycles 5..14.
    lat = 1; do_reset(2);
    for (int c = 0; c < 30; c++) step(0, 0, '0, (c >= 5 && c <= 14), 1);
    #1;
    chk("stream_req_c0", req_log[0], 1);
    if (have("stream_pushes", 5)) begin
      chk("push0_cyc", push_cyc[0], 2);  chk("push0_pc", push_pc[0], 16'h0000);
      chk("push1_cyc", push_cyc[1], 3);  chk("push1_pc", push_pc[1], 16'h0001);
      chk("push2_cyc", push_cyc[2], 4);  chk("push2_pc", push_pc[2], 16'h0002);
      chk("full_resume_cyc", push_cyc[3], 15); chk("full_resume_pc", push_pc[3], 16'h0003);
    end
    chk("full_credit_stall", req_log[7], 0);

    // Branch at cycle 6 with requests in flight and a buffered word.
    lat = 2; do_reset(2);
    for (int c = 0; c < 20; c++) step(0, (c == 6), 16'h0100, 0, 1);
    #1;
    k = -1;
    foreach (push_cyc[i]) if (k < 0 && push_cyc[i] > 6) k = i;
    chk("branch_has_push", (k >= 0), 1);
    if (k >= 0) chk("branch_first_pc", push_pc[k], 16'h0100);

    // Out-of-order response: 0x0005 returned while 0x0004 expected.
    lat = 1; corrupt4 = 1; do_reset(2);
    for (int c = 0; c < 20; c++) step(0, 0, '0, 0, 1);
    #1;
    corrupt4 = 0;
    chk("err_sticky", o_err, 1);
    if (have("badaddr_pushes", 5)) begin
      chk("badaddr_prev", push_pc[3], 16'h0003);
      chk("badaddr_skip", push_pc[4], 16'h0005);
    end

    // Address wrap at 0xFFFF.
    do_reset(2);
    step(0, 1, 16'hFFFE, 0, 1);
    for (int c = 0; c < 10; c++) step(0, 0, '0, 0, 1);
    #1;
    if (have("wrap_pushes", 3)) begin
      chk("wrap_p0", push_pc[0], 16'hFFFE);
      chk("wrap_p1", push_pc[1], 16'hFFFF);
      chk("wrap_p2", push_pc[2], 16'h0000);
    end

    // Reset mid-stream with several requests in flight.
    lat = 3; do_reset(2);
    for (int c = 0; c < 8; c++) step(0, 0, '0, 0, 1);
    do_reset(2);
    for (int c = 0; c < 6; c++) step(0, 0, '0, 0, 1);
    #1;
    chk("rst_req_c0", req_log[0], 1);
    chk("rst_first_addr", got_first ? first_req : 16'hDEAD, 16'h0000);

    // Randomized traffic, including occasional branches and resets.
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      lat = $urandom_range(1, 4);
      t = 16'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0), t,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 10; c++) step(0, 0, '0, 0, 1);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
